pipe_adder: RTL and testbench

Parametrised, pipelined N-bit binary adder with carry-in, carry-out and valid/ready flow control. Operands are split into STAGES equal chunks. Each pipeline stage adds one chunk and passes its carry to the next stage through a register. This is the successor of the team's combinational half/full-adder and 4-bit ripple adder: it keeps full-adder arithmetic per bit, and adds configurable width, pipelining and backpressure. It is intended for datapaths that need wide additions at high clock rates.

---
 rtl/adder_pkg.sv | 16 +
 rtl/adder_chunk.sv | 29 ++
 rtl/pipe_adder.sv | 122 ++++++++++++
 tb/tb_pipe_adder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder.
package adder_pkg;

  localparam int unsigned DefWidth  = 16;
  localparam int unsigned DefStages = 4;

  // True when the operand splits into equal per-stage chunks.
  function automatic bit width_ok(input int unsigned width, input int unsigned stages);
    return (stages != 0) && ((width % stages) == 0);
  endfunction

  function automatic int unsigned chunk_of(input int unsigned width, input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// c_msb is the carry into the top bit, used for signed-overflow detection.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit ripple per stage, valid/ready flow control.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output out_ov.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STAGES = DefStages
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             out_ov
`endif
);

  localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES) || (WIDTH < 2)) begin : g_bad_cfg
    $error("pipe_adder: STAGES must divide WIDTH and WIDTH must be at least 2");
  end

  logic                          adv;
  logic [STAGES-1:0]             v_q, c_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic [STAGES-1:0]             v_src, c_src;
  logic [STAGES-1:0][WIDTH-1:0]  a_src, b_src, s_src, s_nxt;
  logic [STAGES-1:0][CHUNK-1:0]  sum;
  logic [STAGES-1:0]             co, c_msb;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  // Stage 0 takes the input beat; later stages take the previous stage's registers.
  always_comb begin
    v_src    = '0;
    c_src    = '0;
    a_src    = '0;
    b_src    = '0;
    s_src    = '0;
    v_src[0] = in_valid;
    c_src[0] = in_ci;
    a_src[0] = in_a;
    b_src[0] = in_b;
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_chunk #(
      .CHUNK(CHUNK)
    ) u_chunk (
      .a    (a_src[k][k*CHUNK +: CHUNK]),
      .b    (b_src[k][k*CHUNK +: CHUNK]),
      .ci   (c_src[k]),
      .s    (sum[k]),
      .co   (co[k]),
      .c_msb(c_msb[k])
    );
  end

  // Sum chunks above stage k are still zero, so OR merges this stage's chunk in.
  always_comb begin
    s_nxt = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      s_nxt[k] = s_src[k] | (WIDTH'(sum[k]) << (k * CHUNK));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else if (adv) begin
      v_q <= v_src;
      c_q <= co;
      a_q <= a_src;
      b_q <= b_src;
      s_q <= s_nxt;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_s     = s_q[STAGES-1];
  assign out_co    = c_q[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
  logic ov_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q <= 1'b0;
    end else if (adv) begin
      ov_q <= c_msb[STAGES-1] ^ co[STAGES-1];
    end
  end

  assign out_ov = ov_q;
`endif

  // Last-stage operand copies and non-final MSB carries have no consumer.
  logic unused_sig;
  assign unused_sig = ^{a_q[STAGES-1], b_q[STAGES-1], c_msb};

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder (WIDTH=16, STAGES=4): directed steps plus a random sweep
// scored against a queue-based arithmetic reference model.
module tb_pipe_adder;

  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ci = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_s;
  logic         out_co;
`ifdef PIPE_ADDER_OVF_EN
  logic         out_ov;
`endif

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_ci    (in_ci),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_co   (out_co)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .out_ov   (out_ov)
`endif
  );

  typedef struct packed {
    logic         ov;
    logic         co;
    logic [W-1:0] s;
  } res_t;

  res_t model_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic res_t ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    res_t       r;
    logic [W:0] t;
    t    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (a[W-1] == b[W-1]) && (r.s[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       input logic v);
    in_a     = a;
    in_b     = b;
    in_ci    = ci;
    in_valid = v;
  endtask

  // One clock: score retirements and acceptances before the edge, check stall hold after it.
  task automatic cycle();
    bit           acc, ret, stall;
    logic [W-1:0] s_prev;
    logic         co_prev;
    res_t         exp_r;
    #2;
    chk("in_ready_rule", in_ready, out_ready || !out_valid);
    acc     = in_valid && in_ready;
    ret     = out_valid && out_ready;
    stall   = out_valid && !out_ready;
    s_prev  = out_s;
    co_prev = out_co;
    if (ret) begin
      if (model_q.size() == 0) begin
        chk("spurious_beat", 1, 0);
      end else begin
        exp_r = model_q.pop_front();
        chk("sb_sum", out_s, exp_r.s);
        chk("sb_co", out_co, exp_r.co);
`ifdef PIPE_ADDER_OVF_EN
        chk("sb_ov", out_ov, exp_r.ov);
`endif
      end
    end
    if (acc) model_q.push_back(ref_add(in_a, in_b, in_ci));
    @(posedge clk);
    #1;
    if (stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_s, s_prev);
      chk("hold_co", out_co, co_prev);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [W-1:0] s,
                            input logic co);
    chk({tag, "_valid"}, out_valid, v);
    if (v) begin
      chk({tag, "_sum"}, out_s, s);
      chk({tag, "_co"}, out_co, co);
    end
  endtask

  task automatic drain(input string tag);
    drive('0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && model_q.size() != 0; i++) cycle();
    chk({tag, "_drained"}, model_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_out("rst", 1'b0, '0, 1'b0);
    chk("rst_sum", out_s, 0);
    chk("rst_co", out_co, 0);
`ifdef PIPE_ADDER_OVF_EN
    chk("rst_ov", out_ov, 0);
`endif
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Carry ripples through every stage; latency is S edges from acceptance
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    drive('0, '0, 1'b0, 1'b0);
    cycle();
    expect_out("carry_l1", 1'b0, '0, 1'b0);
    cycle();
    expect_out("carry_l2", 1'b0, '0, 1'b0);
    cycle();
    expect_out("carry_a", 1'b1, 16'h0000, 1'b1);
    drive(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    cycle();
    drive('0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    expect_out("carry_ci", 1'b1, 16'h0000, 1'b1);
    cycle();

    // Back-to-back beats with no bubbles
    drive(16'h1234, 16'h1111, 1'b0, 1'b1);
    cycle();
    drive(16'h00FF, 16'h0001, 1'b0, 1'b1);
    cycle();
    drive(16'h8000, 16'h8000, 1'b0, 1'b1);
    cycle();
    drive('0, '0, 1'b0, 1'b0);
    cycle();
    expect_out("b2b_0", 1'b1, 16'h2345, 1'b0);
    cycle();
    expect_out("b2b_1", 1'b1, 16'h0100, 1'b0);
    cycle();
    expect_out("b2b_2", 1'b1, 16'h0000, 1'b1);
    cycle();
    expect_out("b2b_end", 1'b0, '0, 1'b0);

    // Backpressure: fill the pipe, stall five cycles, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      cycle();
    end
    chk("bp_full_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    drain("bp");

    // Asynchronous reset with three beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(W'($urandom), W'($urandom), 1'b0, 1'b1);
      cycle();
    end
    drive('0, '0, 1'b0, 1'b0);
    cycle();
    chk("pre_rst_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sum", out_s, 0);
    chk("arst_co", out_co, 0);
    model_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("no_stale_beat", out_valid, 0);
    end

`ifdef PIPE_ADDER_OVF_EN
    drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    drive('0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    chk("ovf_pos", out_ov, 1);
    chk("ovf_pos_sum", out_s, 16'h8000);
    drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    cycle();
    drive('0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    cycle();
    chk("ovf_none", out_ov, 0);
    chk("ovf_none_co", out_co, 1);
    cycle();
`endif

    // Random sweep with random valid and ready
    for (int i = 0; i < 3000; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
      out_ready = $urandom_range(0, 9) < 7;
      cycle();
    end
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
